// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Decoupled instruction-fetch stage. Issues sequential word-aligned PCs to
//   instruction memory, collects in-order responses into a DEPTH-entry queue
//   and presents {pc, instruction} to decode. An execute-stage redirect
//   flushes the queue, and any fetch still in flight is marked stale and
//   dropped when its response returns.
//
//   Optional build macro FETCH_MISALIGN_TRAP_EN: a redirect to a target with
//   nonzero low bits raises fetch_misaligned and halts fetch until an aligned
//   redirect or rst. Without it the low two target bits are cleared.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   pc_select_execute             redirect strobe
//   pc_target_execute [XLEN]      redirect target
//   imem_req_valid/ready/addr     fetch request channel
//   imem_rsp_valid/data           in-order fetch response (latency >= 1)
//   instr_valid/ready             queue head handshake toward decode
//   pc_fetch, next_pc_fetch       head PC and head PC + 4
//   instruction_fetch             head instruction word
//   fetch_misaligned              misaligned-redirect flag
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_select_execute,
    input  logic [XLEN-1:0] pc_target_execute,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] pc_fetch,
    output logic [XLEN-1:0] next_pc_fetch,
    output logic [XLEN-1:0] instruction_fetch,
    output logic            fetch_misaligned
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic            halted;
    logic            misaligned;
    logic [XLEN-1:0] target;

    logic issue;
    logic rsp_take;
    logic push;
    logic pop;
    logic [CW:0] credit_used;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target = pc_target_execute;

    always_ff @(posedge clk) begin
        if (rst) begin
            halted     <= 1'b0;
            misaligned <= 1'b0;
        end else if (pc_select_execute) begin
            halted     <= |pc_target_execute[1:0];
            misaligned <= |pc_target_execute[1:0];
        end
    end
`else
    logic unused_target_lsbs;

    assign target             = {pc_target_execute[XLEN-1:2], 2'b00};
    assign unused_target_lsbs = ^pc_target_execute[1:0];
    assign halted             = 1'b0;
    assign misaligned         = 1'b0;
`endif

    // Credit counts both queued entries and fetches in flight, so every
    // accepted request is guaranteed a free slot when its response lands.
    assign credit_used    = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = !rst && !pc_select_execute && !halted
                            && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = req_pc;
    assign issue          = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error (or a leftover
    // from before reset) and is ignored entirely.
    assign rsp_take = imem_rsp_valid && (outstanding != '0);
    assign push     = rsp_take && (drop_cnt == '0);
    assign pop      = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (pc_select_execute) begin
            // Redirect overrides pop, push and issue in the same cycle; every
            // fetch still in flight after this cycle's response is stale.
            req_pc      <= target;
            rsp_pc      <= target;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(rsp_take);
            drop_cnt    <= outstanding - CW'(rsp_take);
        end else begin
            if (issue)
                req_pc <= req_pc + XLEN'(4);
            outstanding <= outstanding + CW'(issue) - CW'(rsp_take);
            if (rsp_take) begin
                if (drop_cnt != '0)
                    drop_cnt <= drop_cnt - CW'(1);
                else
                    rsp_pc <= rsp_pc + XLEN'(4);
            end
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage carries no reset; the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push && !pc_select_execute && !rst) begin
            q_pc[wr_ptr]    <= rsp_pc;
            q_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    assign instr_valid       = (count != '0);
    assign pc_fetch          = instr_valid ? q_pc[rd_ptr] : '0;
    assign instruction_fetch = instr_valid ? q_instr[rd_ptr] : '0;
    assign next_pc_fetch     = instr_valid ? (q_pc[rd_ptr] + XLEN'(4)) : '0;
    assign fetch_misaligned  = misaligned;

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_select_execute;
    logic [31:0] pc_target_execute;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_fetch;
    logic [31:0] next_pc_fetch;
    logic [31:0] instruction_fetch;
    logic        fetch_misaligned;

    int          n_cmp = 0;
    int          n_err = 0;
    int          lat   = 1;
    logic        pipe_v [4];
    logic [31:0] pipe_a [4];
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    logic        saw_wrap;

    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_select_execute (pc_select_execute),
        .pc_target_execute (pc_target_execute),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .pc_fetch          (pc_fetch),
        .next_pc_fetch     (next_pc_fetch),
        .instruction_fetch (instruction_fetch),
        .fetch_misaligned  (fetch_misaligned)
    );

    always #5 clk = ~clk;

    // Instruction word stored at a given address in the memory model.
    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h13579BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: capture handshakes at the falling edge, advance the
    // fixed-latency memory model after the rising edge, then check that
    // issued addresses and consumed instructions are strictly sequential.
    task automatic tick();
        logic        f, p, r;
        logic [31:0] fa, pp, pi;
        @(negedge clk);
        r  = rst;
        f  = imem_req_valid && imem_req_ready && !rst;
        fa = imem_req_addr;
        p  = instr_valid && instr_ready && !rst;
        pp = pc_fetch;
        pi = instruction_fetch;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                pipe_v[i] = 1'b0;
                pipe_a[i] = 32'h0;
            end
        end else begin
            for (int i = 3; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_a[i] = pipe_a[i-1];
            end
            pipe_v[0] = f;
            pipe_a[0] = fa;
        end
        imem_rsp_valid = pipe_v[lat-1];
        imem_rsp_data  = dat(pipe_a[lat-1]);
        if (f) begin
            chk("req_addr_seq", fa, exp_req);
            if (fa == 32'h0) saw_wrap = 1'b1;
            exp_req = exp_req + 32'd4;
        end
        if (p) begin
            chk("pop_pc_seq", pp, exp_pc);
            chk("pop_instr", pi, dat(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic do_reset(input int l, input logic rdy);
        lat               = l;
        rst               = 1'b1;
        pc_select_execute = 1'b0;
        pc_target_execute = 32'h0;
        imem_req_ready    = 1'b1;
        instr_ready       = rdy;
        tick();
        tick();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_pc_fetch", pc_fetch, 32'h0);
        chk("rst_next_pc", next_pc_fetch, 32'h0);
        chk("rst_instr", instruction_fetch, 32'h0);
        chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'h0);
        exp_req = 32'h0;
        exp_pc  = 32'h0;
        rst     = 1'b0;
        #1;
    endtask

    task automatic redirect(input logic [31:0] t);
        pc_select_execute = 1'b1;
        pc_target_execute = t;
        #1;
        chk("redir_no_req", {31'b0, imem_req_valid}, 32'h0);
        tick();
        pc_select_execute = 1'b0;
        exp_req = t & ~32'h3;
        exp_pc  = t & ~32'h3;
        #1;
    endtask

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        saw_wrap       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = 32'h0;
        end

        // 1: single-cycle memory, decode always ready
        do_reset(1, 1'b1);
        chk("t1_c0_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("t1_c0_addr", imem_req_addr, 32'h0);
        tick();
        chk("t1_c1_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("t1_c1_addr", imem_req_addr, 32'h4);
        tick();
        for (int k = 2; k < 9; k++) begin
            chk("t1_stream_valid", {31'b0, instr_valid}, 32'h1);
            chk("t1_stream_pc", pc_fetch, 32'(4 * (k - 2)));
            chk("t1_stream_next", next_pc_fetch, 32'(4 * (k - 1)));
            tick();
        end

        // 2: decode stalled, queue fills and credit stops requests
        do_reset(1, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        chk("t2_c4_req_stop", {31'b0, imem_req_valid}, 32'h0);
        tick();
        chk("t2_c5_head_pc", pc_fetch, 32'h0);
        for (int k = 0; k < 5; k++) tick();
        chk("t2_hold_req", {31'b0, imem_req_valid}, 32'h0);
        chk("t2_hold_pc", pc_fetch, 32'h0);
        chk("t2_hold_instr", instruction_fetch, dat(32'h0));
        instr_ready = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        chk("t2_drain_count", exp_pc, 32'd48);

        // 3: latency 3, redirect with two fetches in flight
        do_reset(3, 1'b1);
        tick();
        tick();
        chk("t3_no_rsp_yet", {31'b0, imem_rsp_valid}, 32'h0);
        redirect(32'h100);
        chk("t3_req_target", imem_req_addr, 32'h100);
        chk("t3_req_valid", {31'b0, imem_req_valid}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            chk("t3_flushed", {31'b0, instr_valid}, 32'h0);
            tick();
        end
        chk("t3_head_valid", {31'b0, instr_valid}, 32'h1);
        chk("t3_head_pc", pc_fetch, 32'h100);
        chk("t3_head_instr", instruction_fetch, dat(32'h100));

        // 4: redirect coinciding with a pop and a response
        do_reset(1, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        chk("t4_pre_pc", pc_fetch, 32'h8);
        chk("t4_pre_rsp", {31'b0, imem_rsp_valid}, 32'h1);
        redirect(32'h40);
        chk("t4_empty", {31'b0, instr_valid}, 32'h0);
        chk("t4_req_addr", imem_req_addr, 32'h40);
        tick();
        chk("t4_still_empty", {31'b0, instr_valid}, 32'h0);
        tick();
        chk("t4_head_pc", pc_fetch, 32'h40);
        chk("t4_head_instr", instruction_fetch, dat(32'h40));

        // 5: random request stalls across the address wrap
        do_reset(1, 1'b1);
        redirect(32'hFFFF_FFF0);
        saw_wrap = 1'b0;
        for (int k = 0; k < 40; k++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        imem_req_ready = 1'b1;
        chk("t5_wrapped", {31'b0, saw_wrap}, 32'h1);

        // 6: misaligned redirect
        do_reset(1, 1'b1);
        tick();
        tick();
        redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t6_misaligned", {31'b0, fetch_misaligned}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            chk("t6_halt_req", {31'b0, imem_req_valid}, 32'h0);
            chk("t6_halt_instr", {31'b0, instr_valid}, 32'h0);
            tick();
        end
        redirect(32'h200);
        chk("t6_cleared", {31'b0, fetch_misaligned}, 32'h0);
        chk("t6_resume_addr", imem_req_addr, 32'h200);
        tick();
        tick();
        chk("t6_resume_pc", pc_fetch, 32'h200);
`else
        chk("t6_no_flag", {31'b0, fetch_misaligned}, 32'h0);
        chk("t6_aligned_addr", imem_req_addr, 32'h100);
        tick();
        tick();
        chk("t6_aligned_pc", pc_fetch, 32'h100);
        chk("t6_aligned_instr", instruction_fetch, dat(32'h100));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
